srl_fifo16: RTL and testbench
=============================

// Module: srl_fifo16
// PURPOSE
//  16-deep, ready/valid FIFO built on the shift-register-with-addressed-read storage style.
//  - Write side: shifts data into the shift register.
//  - Read side: tracks occupancy and drives the read address so the oldest entry is always
//    presented at the output.
//  Used as the short elastic buffer between control/DSP stages where block RAM is wasteful.
// PARAMETERS
//  WIDTH  18  data width in bits
// PORTS
//  clk        in   1      clock; all logic on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  clear      in   1      synchronous flush; same effect as reset on control state
//  i_tdata    in   WIDTH  write data
//  i_tvalid   in   1      write data valid
//  i_tready   out  1      FIFO can accept (not full)
//  o_tdata    out  WIDTH  oldest entry
//  o_tvalid   out  1      FIFO not empty
//  o_tready   in   1      consumer accepts o_tdata
//  occupied   out  5      entries held, 0..16
//  space      out  5      free slots, 16-occupied
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous) and clear=1:
//   - occupied=0, space=16, o_tvalid=0, i_tready=1.
//   - Storage array is NOT reset; contents are don't-care.
//   - o_tdata is undefined while o_tvalid=0.
//   - clear has priority over any push/pop in the same cycle.
//  Handshake:
//   - push = i_tvalid & i_tready; pop = o_tvalid & o_tready.
//   - i_tready = (occupied!=16); o_tvalid = (occupied!=0). Both are registered-state
//     decodes with no combinational path from i_tvalid/o_tready.
//  Storage:
//   - On push, mem[0]<=i_tdata and mem[k]<=mem[k-1] for k=1..15 (shift enable = push only).
//   - Read address rd = occupied-1 (4 bits); o_tdata = mem[rd] (combinational mux of
//     registered storage).
//  Occupancy update per cycle:
//   - push & !pop: occupied+1
//   - pop & !push: occupied-1
//   - both or neither: unchanged. Simultaneous push+pop shifts data while rd stays put,
//     so the next-oldest entry appears next cycle.
//  Latency: a word pushed into an empty FIFO at edge N gives o_tvalid=1 and valid o_tdata
//   after edge N (visible in cycle N+1); fall-through, 1 cycle.
//  Boundaries:
//   - Full (16): i_tready=0. A push is refused even if a pop occurs the same cycle;
//     i_tready reasserts the cycle after the pop.
//   - Empty (0): o_tvalid=0; o_tready is ignored; occupied never underflows.
//   - 15->16 and 1->0 transitions update i_tready/o_tvalid on the following edge only.
//   - Ordering is strictly FIFO; no data is duplicated or dropped across any push/pop pattern.
//   - rst_n or clear mid-burst discards all held entries; first push afterwards is
//     output first.
// TESTING
//  1. Reset, push 0x00001 once, o_tready=0 -> next cycle o_tvalid=1, o_tdata=0x00001,
//     occupied=1, space=15.
//  2. Push 16 words 1..16 with o_tready=0 -> i_tready=0 after 16th push; 17th value
//     is not accepted; occupied=16.
//  3. Full, o_tready=1 and i_tvalid=1 held -> pop of 1 is accepted with no push that
//     cycle; next cycle push accepted; outputs read 1,2,3,... in order.
//  4. occupied=5, simultaneous push/pop every cycle for 20 cycles -> occupied stays 5;
//     output sequence is contiguous with no gaps or repeats.
//  5. occupied=9, assert clear for 1 cycle with push+pop -> occupied=0, o_tvalid=0;
//     next push 0x3FFFF emerges first.
//  6. rst_n pulsed low asynchronously mid-burst (between edges) -> o_tvalid=0 and
//     i_tready=1 immediately; occupied=0.

Source files
------------

// File: rtl/srl_fifo16.sv
// 16-deep ready/valid FIFO: data shifts in at mem[0] on each push, and the oldest
// entry is read out at address occupied-1, so a word falls through in one cycle.
module srl_fifo16 #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [4:0]       occupied,
    output logic [4:0]       space
);

    logic [WIDTH-1:0] mem [16];
    logic [4:0]       count;
    logic [3:0]       rd;
    logic             push;
    logic             pop;

    // Flags decode the registered count only, so neither has a combinational
    // path from i_tvalid or o_tready; a full FIFO refuses a push even while popping.
    assign i_tready = (count != 5'd16);
    assign o_tvalid = (count != 5'd0);
    assign push     = i_tvalid & i_tready;
    assign pop      = o_tvalid & o_tready;

    // At count=16 the low nibble is 0 and wraps to 15, the oldest slot.
    assign rd       = count[3:0] - 4'd1;
    assign o_tdata  = mem[rd];
    assign occupied = count;
    assign space    = 5'd16 - count;

    // NOTE: storage has no reset; its contents are don't-care whenever count says
    // the slot is empty, and leaving it unreset keeps it a plain shift register.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[0] <= i_tdata;
            for (int k = 1; k < 16; k++) begin
                mem[k] <= mem[k-1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 5'd0;
        end else if (clear) begin
            count <= 5'd0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_srl_fifo16.sv
// Directed bench for srl_fifo16: a negedge monitor scoreboards every accepted push
// and checks every pop in order; directed checks cover flags, counts and flushes.
module tb_srl_fifo16;

    localparam int WIDTH = 18;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] i_tdata = '0;
    logic             i_tvalid = 1'b0;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tvalid;
    logic             o_tready = 1'b0;
    logic [4:0]       occupied;
    logic [4:0]       space;

    int               checks = 0;
    int               errors = 0;
    int               pop_count = 0;
    logic [WIDTH-1:0] sb [$];

    srl_fifo16 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .occupied (occupied),
        .space    (space)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Inputs are stable mid-cycle, so the negedge sees exactly the handshakes
    // that the next rising edge will commit.
    always @(negedge clk) begin
        if (!rst_n || clear) begin
            sb.delete();
        end else begin
            if (o_tvalid && o_tready) begin
                pop_count++;
                if (sb.size() == 0) begin
                    check("pop_unexpected", {14'd0, o_tdata}, 32'hFFFF_FFFF);
                end else begin
                    check("pop_data", {14'd0, o_tdata}, {14'd0, sb.pop_front()});
                end
            end
            if (i_tvalid && i_tready) sb.push_back(i_tdata);
        end
    end

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
        i_tvalid = v;
        i_tdata  = d;
        o_tready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        for (int n = 0; n < 40 && o_tvalid; n++) begin
            @(posedge clk);
            #1;
        end
        o_tready = 1'b0;
        check("drain_done_tvalid", {31'd0, o_tvalid}, 32'd0);
        check("drain_sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_occupied", {27'd0, occupied}, 32'd0);
        check("rst_space", {27'd0, space}, 32'd16);
        check("rst_o_tvalid", {31'd0, o_tvalid}, 32'd0);
        check("rst_i_tready", {31'd0, i_tready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single push falls through in one cycle
        drive(1'b1, 18'h00001, 1'b0);
        i_tvalid = 1'b0;
        check("t1_o_tvalid", {31'd0, o_tvalid}, 32'd1);
        check("t1_o_tdata", {14'd0, o_tdata}, 32'h1);
        check("t1_occupied", {27'd0, occupied}, 32'd1);
        check("t1_space", {27'd0, space}, 32'd15);

        // 2: fill to 16, 17th value refused
        for (int v = 2; v <= 16; v++) drive(1'b1, WIDTH'(v), 1'b0);
        check("t2_i_tready_full", {31'd0, i_tready}, 32'd0);
        check("t2_occupied_full", {27'd0, occupied}, 32'd16);
        check("t2_space_full", {27'd0, space}, 32'd0);
        drive(1'b1, 18'd17, 1'b0);
        drive(1'b1, 18'd17, 1'b0);
        check("t2_occupied_refused", {27'd0, occupied}, 32'd16);
        check("t2_head_full", {14'd0, o_tdata}, 32'd1);

        // 3: pop at full with push held: push refused that cycle, accepted next
        pop_count = 0;
        drive(1'b1, 18'd17, 1'b1);
        check("t3_occupied_after_pop", {27'd0, occupied}, 32'd15);
        check("t3_i_tready_reassert", {31'd0, i_tready}, 32'd1);
        drive(1'b1, 18'd17, 1'b1);
        check("t3_occupied_push_pop", {27'd0, occupied}, 32'd15);
        drain();
        check("t3_pop_count", pop_count, 32'd17);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        check("t3_no_underflow", {27'd0, occupied}, 32'd0);

        // 4: occupancy 5, simultaneous push/pop for 20 cycles
        for (int v = 100; v < 105; v++) drive(1'b1, WIDTH'(v), 1'b0);
        check("t4_occupied_5", {27'd0, occupied}, 32'd5);
        for (int v = 105; v < 125; v++) drive(1'b1, WIDTH'(v), 1'b1);
        i_tvalid = 1'b0;
        o_tready = 1'b0;
        check("t4_occupied_steady", {27'd0, occupied}, 32'd5);
        check("t4_head", {14'd0, o_tdata}, 32'd120);
        drain();

        // 5: clear with push+pop at occupancy 9
        for (int v = 200; v < 209; v++) drive(1'b1, WIDTH'(v), 1'b0);
        check("t5_occupied_9", {27'd0, occupied}, 32'd9);
        clear = 1'b1;
        drive(1'b1, 18'd999, 1'b1);
        clear = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b0;
        check("t5_clear_occupied", {27'd0, occupied}, 32'd0);
        check("t5_clear_o_tvalid", {31'd0, o_tvalid}, 32'd0);
        check("t5_clear_space", {27'd0, space}, 32'd16);
        drive(1'b1, 18'h3FFFF, 1'b0);
        check("t5_first_after_clear", {14'd0, o_tdata}, 32'h3FFFF);
        drive(1'b1, 18'h12345, 1'b0);
        drain();

        // 6: asynchronous reset mid-burst
        for (int v = 300; v < 307; v++) drive(1'b1, WIDTH'(v), 1'b0);
        check("t6_occupied_7", {27'd0, occupied}, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_o_tvalid", {31'd0, o_tvalid}, 32'd0);
        check("t6_rst_i_tready", {31'd0, i_tready}, 32'd1);
        check("t6_rst_occupied", {27'd0, occupied}, 32'd0);
        i_tvalid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 18'h00ABC, 1'b0);
        check("t6_first_after_rst", {14'd0, o_tdata}, 32'hABC);
        drive(1'b1, 18'h00DEF, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
